// File: rtl/ro_meas_pkg.sv
// Shared types and constants for the ring-oscillator frequency counter.
package ro_meas_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_GATE_CYCLES = 64;
  localparam int unsigned DEF_CNT_W       = 12;

  // Largest value representable in w bits (saturation ceiling of the edge count).
  function automatic int unsigned sat_value(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/ro_freq_counter_if.sv
// Start/done measurement handshake and result bus.
interface ro_freq_counter_if #(
  parameter int unsigned CNT_W = 12
) ();

  logic             start;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] count;
  logic             overflow;

  modport master (output start, input busy, input done, input count, input overflow);
  modport slave  (input start, output busy, output done, output count, output overflow);

endinterface

// File: rtl/ro_sync_edge.sv
// Two-flop synchroniser plus history flop; flags each synchronised rising edge.
module ro_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic ro_in,
  output logic rise
);

  logic s1;
  logic s2;
  logic p;

  // Synchroniser chain and edge history, running in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      p  <= 1'b0;
    end else begin
      s1 <= ro_in;
      s2 <= s1;
      p  <= s2;
    end
  end

  assign rise = s2 & ~p;

endmodule

// File: rtl/ro_freq_counter.sv
// Counts ro_in rising edges over a GATE_CYCLES window; start/done handshaked.
module ro_freq_counter
  import ro_meas_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ro_in,
  ro_freq_counter_if.slave bus
);

  localparam int unsigned      GATE_W    = $clog2(GATE_CYCLES);
  localparam logic [CNT_W-1:0]  SAT       = CNT_W'(sat_value(CNT_W));
  localparam logic [GATE_W-1:0] GATE_LOAD = GATE_W'(GATE_CYCLES - 1);

  state_t            state_q;
  state_t            state_d;
  logic [GATE_W-1:0] gate_q;
  logic [GATE_W-1:0] gate_d;
  logic [CNT_W-1:0]  acc_q;
  logic [CNT_W-1:0]  acc_d;
  logic              ovf_acc_q;
  logic              ovf_acc_d;
  logic              busy_q;
  logic              busy_d;
  logic              done_q;
  logic              done_d;
  logic [CNT_W-1:0]  count_q;
  logic              overflow_q;
  logic              load_c;
  logic              rise;

  ro_sync_edge u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .ro_in (ro_in),
    .rise  (rise)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start only matters in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = GATE;
      GATE:    if (gate_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Gate counter, saturating accumulator and next values of the registered outputs.
  always_comb begin
    gate_d    = gate_q;
    acc_d     = acc_q;
    ovf_acc_d = ovf_acc_q;
    busy_d    = (state_d == GATE);
    done_d    = (state_d == DONE);
    load_c    = (state_d == DONE);
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          gate_d    = GATE_LOAD;
          acc_d     = '0;
          ovf_acc_d = 1'b0;
        end
      end
      GATE: begin
        // The rise in the final gate cycle is still counted.
        if (rise) begin
          if (acc_q == SAT) ovf_acc_d = 1'b1;
          else              acc_d     = acc_q + CNT_W'(1);
        end
        if (gate_q != '0) gate_d = gate_q - GATE_W'(1);
      end
      default: ;
    endcase
  end

  // Datapath and output registers; results load on entry to DONE and then hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_q     <= '0;
      acc_q      <= '0;
      ovf_acc_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      gate_q    <= gate_d;
      acc_q     <= acc_d;
      ovf_acc_q <= ovf_acc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      if (load_c) begin
        count_q    <= acc_d;
        overflow_q <= ovf_acc_d;
      end
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_ro_freq_counter.sv
// Directed bench: a 12-bit counter for nominal cases, a 4-bit one for saturation.
module tb_ro_freq_counter;

  logic       clk;
  logic       rst_n;
  logic       ro_in;
  logic       start_req;
  logic       sel;
  int         half;
  int         ph;
  int         checks;
  int         errors;

  logic        cur_busy;
  logic        cur_done;
  logic        cur_ovf;
  logic [11:0] cur_count;

  typedef struct {
    int half;
    int exp_cnt;
    bit exp_ovf;
  } vec_t;

  vec_t vecs [6];

  ro_freq_counter_if #(.CNT_W(12)) bus ();
  ro_freq_counter_if #(.CNT_W(4))  bus_s ();

  assign bus.start   = start_req & ~sel;
  assign bus_s.start = start_req & sel;

  ro_freq_counter #(.GATE_CYCLES(64), .CNT_W(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ro_in (ro_in),
    .bus   (bus)
  );

  ro_freq_counter #(.GATE_CYCLES(64), .CNT_W(4)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .ro_in (ro_in),
    .bus   (bus_s)
  );

  always_comb begin
    if (sel) begin
      cur_busy  = bus_s.busy;
      cur_done  = bus_s.done;
      cur_ovf   = bus_s.overflow;
      cur_count = 12'(bus_s.count);
    end else begin
      cur_busy  = bus.busy;
      cur_done  = bus.done;
      cur_ovf   = bus.overflow;
      cur_count = bus.count;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Oscillator model: toggles every `half` clocks, held low when half is 0.
  initial begin
    ro_in = 1'b0;
    ph    = 0;
    forever begin
      @(negedge clk);
      if (half == 0) begin
        ro_in = 1'b0;
        ph    = 0;
      end else begin
        ph++;
        if (ph >= half) begin
          ro_in = ~ro_in;
          ph    = 0;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One measurement: pulse start, watch 80 cycles, check latency, busy width and result.
  task automatic run_meas(input string name, input int exp_cnt, input bit exp_ovf);
    int busy_n;
    int done_n;
    int done_at;
    int cnt_at_done;
    busy_n = 0; done_n = 0; done_at = 0; cnt_at_done = -1;
    @(negedge clk);
    start_req = 1'b1;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (i == 1) start_req = 1'b0;
      if (cur_busy) busy_n++;
      if (cur_done) begin
        done_n++;
        if (done_at == 0) begin
          done_at     = i;
          cnt_at_done = int'(cur_count);
        end
      end
    end
    check({name, "_done_latency"}, done_at, 65);
    check({name, "_done_pulses"}, done_n, 1);
    check({name, "_busy_cycles"}, busy_n, 64);
    check({name, "_count_at_done"}, cnt_at_done, exp_cnt);
    check({name, "_count"}, int'(cur_count), exp_cnt);
    check({name, "_overflow"}, int'(cur_ovf), int'(exp_ovf));
  endtask

  initial begin
    int busy_n;
    int done_n;
    int done_at;
    int done2_at;
    int mid_cnt;
    bit b66;
    bit b67;

    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    start_req = 1'b0;
    sel       = 1'b0;
    half      = 0;

    vecs[0] = '{half: 0,  exp_cnt: 0,  exp_ovf: 1'b0};
    vecs[1] = '{half: 4,  exp_cnt: 8,  exp_ovf: 1'b0};
    vecs[2] = '{half: 2,  exp_cnt: 16, exp_ovf: 1'b0};
    vecs[3] = '{half: 8,  exp_cnt: 4,  exp_ovf: 1'b0};
    vecs[4] = '{half: 16, exp_cnt: 2,  exp_ovf: 1'b0};
    vecs[5] = '{half: 1,  exp_cnt: 32, exp_ovf: 1'b0};

    // Reset state.
    settle(3);
    check("rst_busy", int'(cur_busy), 0);
    check("rst_done", int'(cur_done), 0);
    check("rst_count", int'(cur_count), 0);
    check("rst_overflow", int'(cur_ovf), 0);
    rst_n = 1'b1;
    settle(2);

    // Table of steady oscillator periods.
    for (int v = 0; v < 6; v++) begin
      half = vecs[v].half;
      settle(40);
      run_meas($sformatf("vec%0d", v), vecs[v].exp_cnt, vecs[v].exp_ovf);
    end

    // Back-to-back windows with start held high.
    half = 4;
    settle(40);
    busy_n = 0; done_n = 0; done_at = 0; done2_at = 0; mid_cnt = -1; b66 = 1'b1; b67 = 1'b0;
    @(negedge clk);
    start_req = 1'b1;
    for (int i = 1; i <= 140; i++) begin
      @(negedge clk);
      if (cur_done) begin
        done_n++;
        if (done_at == 0) done_at = i;
        else if (done2_at == 0) done2_at = i;
      end
      if (i == 66) b66 = cur_busy | cur_done;
      if (i == 67) b67 = cur_busy;
      if (i == 100) mid_cnt = int'(cur_count);
    end
    start_req = 1'b0;
    check("b2b_first_done", done_at, 65);
    check("b2b_second_done", done2_at, 131);
    check("b2b_done_pulses", done_n, 2);
    check("b2b_idle_gap", int'(b66), 0);
    check("b2b_busy_again", int'(b67), 1);
    check("b2b_count_held_mid", mid_cnt, 8);
    check("b2b_count", int'(cur_count), 8);
    settle(80);

    // Start pulses in GATE and in DONE are ignored.
    busy_n = 0; done_n = 0; done_at = 0;
    @(negedge clk);
    start_req = 1'b1;
    for (int i = 1; i <= 150; i++) begin
      @(negedge clk);
      if (i == 1 || i == 11 || i == 66) start_req = 1'b0;
      if (i == 10 || i == 65) start_req = 1'b1;
      if (cur_busy) busy_n++;
      if (cur_done) begin
        done_n++;
        if (done_at == 0) done_at = i;
      end
    end
    check("ign_done_pulses", done_n, 1);
    check("ign_done_latency", done_at, 65);
    check("ign_busy_cycles", busy_n, 64);
    check("ign_count", int'(cur_count), 8);

    // Result holds while the oscillator changes and no start arrives.
    half = 2;
    done_n = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (cur_done | cur_busy) done_n++;
    end
    check("hold_no_activity", done_n, 0);
    check("hold_count", int'(cur_count), 8);
    run_meas("hold_new", 16, 1'b0);

    // Asynchronous reset in the middle of a window.
    half = 4;
    settle(40);
    @(negedge clk);
    start_req = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 1) start_req = 1'b0;
    end
    check("mid_busy_before", int'(cur_busy), 1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", int'(cur_busy), 0);
    check("mid_rst_done", int'(cur_done), 0);
    check("mid_rst_count", int'(cur_count), 0);
    check("mid_rst_overflow", int'(cur_ovf), 0);
    settle(2);
    rst_n = 1'b1;
    done_n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cur_done | cur_busy) done_n++;
    end
    check("mid_rst_quiet", done_n, 0);

    // Saturation on the 4-bit counter, then a clean window.
    sel  = 1'b1;
    half = 1;
    settle(20);
    run_meas("sat", 15, 1'b1);
    half = 0;
    settle(10);
    run_meas("sat_clear", 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ro_freq_counter.md
Name: ro_freq_counter

Overview:
- Measures the ring oscillator built from the team's delay-modelled inverter cells by counting its rising edges over a fixed window of system clocks.
- Sits on the clocked side of the oscillator. It synchronises the free-running, asynchronous oscillator tap and presents a count plus a done strobe to the project's I/O logic.
- Measurement is start/done handshaked. The result is held until the next measurement completes.

Parameters:
- GATE_CYCLES, 64: length of the measurement window in clk cycles; minimum 2.
- CNT_W, 12: width of the edge count result.
- GATE_W, $clog2(GATE_CYCLES): width of the gate counter; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ro_in  input  1  oscillator tap; asynchronous to clk.
- start  input  1  request a measurement; sampled only in IDLE.
- busy  output  1  high while a measurement window is open (GATE state).
- done  output  1  one-cycle pulse; count and overflow are valid from this cycle onward.
- count  output  CNT_W  number of ro_in rising edges seen in the last window.
- overflow  output  1  the last window saturated count.

Behaviour:
- Reset (rst_n low, asynchronous): all flops clear.
  - FSM to IDLE.
  - busy=0, done=0, count=0, overflow=0.
  - Synchroniser and edge-history flops cleared to 0.
- Reset asserted mid-measurement aborts the measurement. No done pulse is produced.
- Synchroniser and edge detect:
  - ro_in passes through a 2-flop synchroniser (s1, s2), then a history flop p.
  - rise = s2 & ~p.
  - This path runs continuously in every state.
  - An ro_in edge reaches rise 2-3 clk cycles after it occurs.
- Valid input range: ro_in high and low phases each ≥1 clk period; edge period ≥2 clk. Faster inputs alias. This is not detected and is documented as out of range.
- FSM states: IDLE, GATE, DONE.
- IDLE:
  - busy=0.
  - If start=1, go to GATE next cycle: gate counter := GATE_CYCLES-1, edge accumulator := 0, overflow accumulator := 0.
  - start=0: stay in IDLE.
- GATE (exactly GATE_CYCLES cycles):
  - busy=1.
  - In each cycle with rise=1, the accumulator increments. It saturates at 2^CNT_W-1; an increment attempted at saturation sets the overflow accumulator.
  - When the gate counter reaches 0, the rise of that same cycle is still counted, and the next state is DONE. Otherwise the gate counter decrements.
  - start is ignored.
- DONE (1 cycle):
  - count := accumulator value, overflow := overflow accumulator.
  - These outputs are registered, so they are visible in the DONE cycle itself.
  - done=1, busy=0.
  - Next state is IDLE unconditionally; start is ignored in DONE.
- count and overflow hold their values until the next DONE. They are unchanged while a new window runs.
- Start held high continuously gives back-to-back windows: GATE×GATE_CYCLES, DONE, IDLE (1 cycle), GATE, and so on.
- Latency from start sampled in IDLE to done: GATE_CYCLES+1 cycles.

Decomposition:
- Package ro_meas_pkg holds:
  - the state enum (IDLE, GATE, DONE);
  - default GATE_CYCLES and CNT_W constants;
  - the saturation value function.
- One sub-module: ro_sync_edge. It contains the 2-flop synchroniser plus the history flop and outputs rise, with clk/rst_n and the same asynchronous active-low reset.
- The FSM, gate counter and accumulator stay in ro_freq_counter.

Test Plan:
- Reset then idle: rst_n low for 3 clk, start pulse, ro_in held 0 for the whole window (GATE_CYCLES=64) -> done pulses 65 cycles after start with count=0, overflow=0. busy high exactly 64 cycles.
- Nominal frequency: ro_in toggles every 4 clk (period 8), steady state before start, GATE_CYCLES=64 -> count=8, overflow=0. A second back-to-back measurement with start held high -> count=8 again, with one IDLE cycle between done and the next busy.
- Saturation: CNT_W=4, ro_in toggles every clk (rise every 2 clk), GATE_CYCLES=64 -> count=15, overflow=1. A following window with ro_in=0 -> count=0, overflow=0.
- Start while busy or in DONE: pulse start at GATE cycle 10 and again in the DONE cycle -> no restart, exactly one done, FSM returns to IDLE and waits.
- Reset mid-window: assert rst_n low at GATE cycle 30 with ro_in period 8 -> busy, done, count and overflow all 0 immediately (asynchronous). No done pulse afterwards until a new start.
- Hold check: after a measurement giving count=8, change ro_in to period 4 and do not start -> count stays 8 indefinitely. Then start -> count=16 at the next done.
